// File: rtl/job_seq_pkg.sv
// job_seq_pkg: shared state encoding and error codes for the job sequencer
package job_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;
endpackage

// File: rtl/watchdog_timer.sv
// watchdog_timer: idle-cycle counter that flags a timeout on the last allowed cycle
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   clr     zero the counter (wins over en)
//   en      count this cycle
//   expired combinational, high when the count has reached TIMEOUT-1 while enabled
module watchdog_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else if (clr) wd_q <= '0;
        else if (en) wd_q <= wd_q + WD_W'(1);
    end
    assign expired = en && (wd_q == WD_W'(TIMEOUT - 1));
endmodule

// File: rtl/job_sequencer.sv
// job_sequencer: runs one worker job (req/ack, beat counting, watchdog) and reports busy/done/error levels
//   clk, rst          clock and asynchronous active-high reset
//   start, len        launch a job of len beats (IDLE or DONE only)
//   abort, clear      cancel an active job / acknowledge DONE or ERROR
//   worker_req/ack    request handshake with the worker engine
//   beat_valid        one worker beat this cycle
//   busy/done/error   mutually exclusive status levels, err_code and beat_count for debug
module job_sequencer
    import job_seq_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             clear,
    output logic             worker_req,
    input  logic             worker_ack,
    input  logic             beat_valid,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] beat_count
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [1:0]       err_q, err_d;
    logic             wd_clr, wd_en, wd_expired;
    assign wd_en = (state_q == S_REQ) || (state_q == S_RUN);
    watchdog_timer #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end
    // Priority inside an active job: abort, then progress (ack/beat), then timeout.
    // The watchdog keeps counting only while a wait continues with no progress.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        wd_clr  = 1'b1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    beat_d  = '0;
                    err_d   = (len != '0) ? ERR_NONE : ERR_ZERO_LEN;
                    state_d = (len != '0) ? S_REQ : S_ERROR;
                    len_d   = (len != '0) ? len : len_q;
                end else if (clear && state_q == S_DONE) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ABORT;
                end else if (worker_ack) begin
                    state_d = S_RUN;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wd_clr = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ABORT;
                end else if (beat_valid) begin
                    beat_d  = beat_q + CNT_W'(1);
                    state_d = (beat_q == len_q - CNT_W'(1)) ? S_DONE : S_RUN;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wd_clr = 1'b0;
                end
            end
            S_ERROR: begin
                if (clear) begin
                    state_d = S_IDLE;
                    err_d   = ERR_NONE;
                    beat_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    assign worker_req = (state_q == S_REQ);
    assign busy_out   = (state_q == S_REQ) || (state_q == S_RUN);
    assign done_out   = (state_q == S_DONE);
    assign error_out  = (state_q == S_ERROR);
    assign err_code   = err_q;
    assign beat_count = beat_q;
endmodule

// File: tb/tb_job_sequencer.sv
// tb_job_sequencer: directed self-checking bench for job_sequencer
module tb_job_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic       worker_req;
    logic       worker_ack = 1'b0;
    logic       beat_valid = 1'b0;
    logic       busy_out, done_out, error_out;
    logic [1:0] err_code;
    logic [7:0] beat_count;
    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    job_sequencer #(.CNT_W(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .clear      (clear),
        .worker_req (worker_req),
        .worker_ack (worker_ack),
        .beat_valid (beat_valid),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .error_out  (error_out),
        .err_code   (err_code),
        .beat_count (beat_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        if (worker_req) req_cycles++;
    endtask
    task automatic status(input string tag, input logic b, d, e, input logic [1:0] c, input logic [7:0] n);
        check({tag, ".busy"}, busy_out, b);
        check({tag, ".done"}, done_out, d);
        check({tag, ".err"}, error_out, e);
        check({tag, ".code"}, err_code, c);
        check({tag, ".beats"}, beat_count, n);
    endtask
    initial begin
        @(negedge clk);
        @(negedge clk);
        status("reset", 0, 0, 0, 2'b00, 8'd0);
        check("reset.req", worker_req, 0);
        rst = 1'b0;
        // ignored inputs while idle
        beat_valid = 1; abort = 1; tick(); beat_valid = 0; abort = 0;
        status("idle_ign", 0, 0, 0, 2'b00, 8'd0);
        // nominal job, len=4
        req_cycles = 0;
        start = 1; len = 8'd4; tick(); start = 0;
        status("nom.start", 1, 0, 0, 2'b00, 8'd0);
        check("nom.req", worker_req, 1);
        tick(); tick();
        worker_ack = 1; tick(); worker_ack = 0;
        check("nom.req_drop", worker_req, 0);
        check("nom.req_cycles", req_cycles, 3);
        beat_valid = 1;
        tick(); tick(); tick();
        status("nom.b3", 1, 0, 0, 2'b00, 8'd3);
        tick(); beat_valid = 0;
        status("nom.done", 0, 1, 0, 2'b00, 8'd4);
        tick();
        status("nom.hold", 0, 1, 0, 2'b00, 8'd4);
        clear = 1; tick(); clear = 0;
        status("nom.clear", 0, 0, 0, 2'b00, 8'd0);
        // zero length
        start = 1; len = 8'd0; tick();
        status("zero", 0, 0, 1, 2'b01, 8'd0);
        len = 8'd3; tick(); start = 0;
        status("zero.start_ign", 0, 0, 1, 2'b01, 8'd0);
        clear = 1; tick(); clear = 0;
        status("zero.clear", 0, 0, 0, 2'b00, 8'd0);
        // ack timeout: error exactly 16 edges after REQ entry
        start = 1; len = 8'd3; tick(); start = 0;
        for (int i = 0; i < 15; i++) tick();
        check("ackto.15.err", error_out, 0);
        check("ackto.15.req", worker_req, 1);
        tick();
        status("ackto.16", 0, 0, 1, 2'b10, 8'd0);
        check("ackto.req", worker_req, 0);
        clear = 1; tick(); clear = 0;
        // beat gap: 15-cycle gap survives, 16-cycle gap times out
        start = 1; len = 8'd5; tick(); start = 0;
        worker_ack = 1; tick(); worker_ack = 0;
        beat_valid = 1; tick(); tick(); beat_valid = 0;
        status("gap.b2", 1, 0, 0, 2'b00, 8'd2);
        for (int i = 0; i < 15; i++) tick();
        status("gap.15", 1, 0, 0, 2'b00, 8'd2);
        beat_valid = 1; tick(); beat_valid = 0;
        status("gap.b3", 1, 0, 0, 2'b00, 8'd3);
        for (int i = 0; i < 15; i++) tick();
        check("gap.16a.busy", busy_out, 1);
        tick();
        status("gap.to", 0, 0, 1, 2'b10, 8'd3);
        beat_valid = 1; tick(); beat_valid = 0;
        check("gap.beat_ign", beat_count, 3);
        clear = 1; tick(); clear = 0;
        // abort beats final beat
        start = 1; len = 8'd2; tick(); start = 0;
        worker_ack = 1; tick(); worker_ack = 0;
        beat_valid = 1; tick();
        abort = 1; tick(); abort = 0; beat_valid = 0;
        status("abort", 0, 0, 1, 2'b11, 8'd1);
        clear = 1; tick(); clear = 0;
        // abort in REQ with same-cycle ack
        start = 1; len = 8'd2; tick(); start = 0;
        abort = 1; worker_ack = 1; tick(); abort = 0; worker_ack = 0;
        status("abort.req", 0, 0, 1, 2'b11, 8'd0);
        clear = 1; tick(); clear = 0;
        // restart from DONE
        start = 1; len = 8'd1; tick(); start = 0;
        worker_ack = 1; tick(); worker_ack = 0;
        beat_valid = 1; tick(); beat_valid = 0;
        status("rs.done", 0, 1, 0, 2'b00, 8'd1);
        start = 1; len = 8'd1; tick(); start = 0;
        status("rs.restart", 1, 0, 0, 2'b00, 8'd0);
        worker_ack = 1; tick(); worker_ack = 0;
        beat_valid = 1; tick(); beat_valid = 0;
        // start and clear together in DONE: start wins
        start = 1; clear = 1; len = 8'd2; tick(); start = 0; clear = 0;
        status("rs.start_wins", 1, 0, 0, 2'b00, 8'd0);
        // clear ignored while active, then async reset mid-RUN
        worker_ack = 1; tick(); worker_ack = 0;
        beat_valid = 1; clear = 1; tick(); beat_valid = 0; clear = 0;
        status("run.clear_ign", 1, 0, 0, 2'b00, 8'd1);
        #2 rst = 1;
        #1;
        status("async_rst", 0, 0, 0, 2'b00, 8'd0);
        check("async_rst.req", worker_req, 0);
        tick(); rst = 0;
        tick();
        status("post_rst", 0, 0, 0, 2'b00, 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
